// File: rtl/dut_test_sequencer.sv
// DUT test sequencer: selects one of NUM_DUT slots, fires a start pulse,
// times the start->ready latency under a watchdog and registers the result.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   START_FLAG      host level request; rising edge starts a run in IDLE
//   SEL             requested slot, latched into sel_q while idle
//   DATA_IN         passed straight through to DUT_DIN
//   DUT_EN          one-hot enable of the latched slot
//   DUT_START       one-cycle start pulse (the ARM cycle)
//   DUT_DOUT/HEAD   flattened per-slot data and header buses
//   DUT_RDY         per-slot ready flags; a rising edge completes a run
//   DATA_OUT        data captured from the last completed run
//   HEAD_INFO       {NUM_DUT[5:0], header of latched slot}
//   CYCLE_CNT       latency of the last run (or count reached at timeout)
//   BUSY, RDY_FLAG  status: ARM/RUN, DONE
//   ERR             0 ok, 1 timeout, 2 slot out of range
module dut_test_sequencer #(
    parameter int BITWIDTH_DATA   = 16,
    parameter int NUM_DUT         = 3,
    parameter int NUM_BITS_HEADER = 32,
    parameter int CNT_WIDTH       = 24,
    parameter int TIMEOUT_CYCLES  = 1000000,
    localparam int SW = (NUM_DUT > 1) ? $clog2(NUM_DUT) : 1,
    localparam int HW = NUM_BITS_HEADER - 6
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START_FLAG,
    input  logic [SW-1:0]                SEL,
    input  logic [BITWIDTH_DATA-1:0]     DATA_IN,
    output logic [NUM_DUT-1:0]           DUT_EN,
    output logic                         DUT_START,
    output logic [BITWIDTH_DATA-1:0]     DUT_DIN,
    input  logic [NUM_DUT*BITWIDTH_DATA-1:0] DUT_DOUT,
    input  logic [NUM_DUT*HW-1:0]        DUT_HEAD,
    input  logic [NUM_DUT-1:0]           DUT_RDY,
    output logic [BITWIDTH_DATA-1:0]     DATA_OUT,
    output logic [NUM_BITS_HEADER-1:0]   HEAD_INFO,
    output logic [CNT_WIDTH-1:0]         CYCLE_CNT,
    output logic                         BUSY,
    output logic                         RDY_FLAG,
    output logic [1:0]                   ERR
);

    localparam int BW = BITWIDTH_DATA;
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0] ND6 = 6'(NUM_DUT);

    typedef enum logic [2:0] {IDLE, ARM, RUN, DONE, ERRST} state_t;

    state_t               state, state_d;
    logic                 start_q;
    logic                 rdy_prev, rdy_prev_d;
    logic [SW-1:0]        sel_q, sel_d;
    logic [CNT_WIDTH-1:0] cnt, cnt_d;
    logic [CNT_WIDTH-1:0] ccnt_q, ccnt_d;
    logic [1:0]           err_q, err_d;
    logic [BW-1:0]        dout_q, dout_d;

    logic                 rdy_sel;
    logic [BW-1:0]        dout_sel;
    logic [HW-1:0]        head_sel;
    logic [NUM_DUT-1:0]   en;
    logic                 start_ev, sel_ok, rdy_rise, timeout_hit;

    // Slot mux driven only by the latched selection, never by SEL directly.
    always_comb begin
        en       = '0;
        rdy_sel  = 1'b0;
        dout_sel = '0;
        head_sel = '0;
        for (int k = 0; k < NUM_DUT; k++) begin
            if (sel_q == SW'(k)) begin
                en[k]    = 1'b1;
                rdy_sel  = DUT_RDY[k];
                dout_sel = DUT_DOUT[k*BW +: BW];
                head_sel = DUT_HEAD[k*HW +: HW];
            end
        end
    end

    assign start_ev    = START_FLAG & ~start_q;
    assign sel_ok      = 32'(SEL) < 32'(NUM_DUT);
    assign rdy_rise    = rdy_sel & ~rdy_prev;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            rdy_prev <= 1'b0;
            sel_q    <= '0;
            cnt      <= '0;
            ccnt_q   <= '0;
            err_q    <= 2'd0;
            dout_q   <= '0;
        end else begin
            state    <= state_d;
            start_q  <= START_FLAG;
            rdy_prev <= rdy_prev_d;
            sel_q    <= sel_d;
            cnt      <= cnt_d;
            ccnt_q   <= ccnt_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
        end
    end

    always_comb begin
        state_d    = state;
        rdy_prev_d = rdy_prev;
        sel_d      = sel_q;
        cnt_d      = cnt;
        ccnt_d     = ccnt_q;
        err_d      = err_q;
        dout_d     = dout_q;
        unique case (state)
            IDLE: begin
                if (sel_ok)
                    sel_d = SEL;
                if (start_ev) begin
                    if (sel_ok) begin
                        state_d = ARM;
                        cnt_d   = '0;
                        err_d   = 2'd0;
                    end else begin
                        state_d = ERRST;
                        err_d   = 2'd2;
                    end
                end
            end
            ARM: begin
                // Ready level seen here is the baseline; only a later
                // rising edge counts as completion.
                rdy_prev_d = rdy_sel;
                state_d    = RUN;
            end
            RUN: begin
                rdy_prev_d = rdy_sel;
                if (cnt != '1)
                    cnt_d = cnt + 1'b1;
                if (rdy_rise) begin
                    dout_d  = dout_sel;
                    ccnt_d  = cnt;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    ccnt_d  = cnt;
                    err_d   = 2'd1;
                    state_d = ERRST;
                end
            end
            DONE, ERRST: begin
                if (!START_FLAG)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign DUT_EN    = en;
    assign DUT_START = (state == ARM);
    assign DUT_DIN   = DATA_IN;
    assign DATA_OUT  = dout_q;
    assign HEAD_INFO = {ND6, head_sel};
    assign CYCLE_CNT = ccnt_q;
    assign BUSY      = (state == ARM) || (state == RUN);
    assign RDY_FLAG  = (state == DONE);
    assign ERR       = err_q;

endmodule

// File: tb/tb_dut_test_sequencer.sv
// Testbench for dut_test_sequencer: directed and randomized runs
// checked against a transaction-level model of latency/timeout rules.
module tb_dut_test_sequencer;

    localparam int BW  = 16;
    localparam int ND  = 3;
    localparam int HB  = 32;
    localparam int HW  = HB - 6;
    localparam int CW  = 24;
    localparam int TO  = 16;

    logic              CLK = 1'b0;
    logic              RST;
    logic              START_FLAG;
    logic [1:0]        SEL;
    logic [BW-1:0]     DATA_IN;
    logic [ND-1:0]     DUT_EN;
    logic              DUT_START;
    logic [BW-1:0]     DUT_DIN;
    logic [ND*BW-1:0]  DUT_DOUT;
    logic [ND*HW-1:0]  DUT_HEAD;
    logic [ND-1:0]     DUT_RDY;
    logic [BW-1:0]     DATA_OUT;
    logic [HB-1:0]     HEAD_INFO;
    logic [CW-1:0]     CYCLE_CNT;
    logic              BUSY;
    logic              RDY_FLAG;
    logic [1:0]        ERR;

    logic [BW-1:0]     dout [ND];
    logic [HW-1:0]     head [ND];
    logic [ND-1:0]     rdy;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: what the host should see in the persistent registers.
    int             exp_sel;
    logic [BW-1:0]  exp_data;
    logic [CW-1:0]  exp_cnt;
    logic [1:0]     exp_err;

    always #5 CLK = ~CLK;

    always_comb begin
        for (int k = 0; k < ND; k++) begin
            DUT_DOUT[k*BW +: BW] = dout[k];
            DUT_HEAD[k*HW +: HW] = head[k];
        end
        DUT_RDY = rdy;
    end

    dut_test_sequencer #(
        .BITWIDTH_DATA(BW),
        .NUM_DUT(ND),
        .NUM_BITS_HEADER(HB),
        .CNT_WIDTH(CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .START_FLAG(START_FLAG),
        .SEL(SEL),
        .DATA_IN(DATA_IN),
        .DUT_EN(DUT_EN),
        .DUT_START(DUT_START),
        .DUT_DIN(DUT_DIN),
        .DUT_DOUT(DUT_DOUT),
        .DUT_HEAD(DUT_HEAD),
        .DUT_RDY(DUT_RDY),
        .DATA_OUT(DATA_OUT),
        .HEAD_INFO(HEAD_INFO),
        .CYCLE_CNT(CYCLE_CNT),
        .BUSY(BUSY),
        .RDY_FLAG(RDY_FLAG),
        .ERR(ERR)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ND-1:0] oh(input int s);
        return ND'(1 << s);
    endfunction

    function automatic logic [HB-1:0] hexp(input int s);
        return {6'(ND), head[s]};
    endfunction

    // One host transaction. d = RUN cycle on which the slot's ready rises;
    // pre = ready already high before start (never rises). alt >= 0 forces
    // SEL to that value while the run is in progress.
    task automatic run_txn(input int sel, input int d, input bit pre,
                           input int hold, input logic [BW-1:0] dval,
                           input int alt);
        int  last;
        bit  ok;
        rdy = '0;
        if (sel < ND) begin
            dout[sel] = dval;
            rdy[sel]  = pre;
        end
        SEL        = 2'(sel);
        START_FLAG = 1'b1;
        DATA_IN    = BW'($urandom);
        @(negedge CLK);
        chk("din_pass", DUT_DIN, DATA_IN);
        if (sel >= ND) begin
            exp_err = 2'd2;
            chk("oor_err", ERR, exp_err);
            chk("oor_busy", BUSY, 0);
            chk("oor_start", DUT_START, 0);
            chk("oor_en", DUT_EN, oh(exp_sel));
            repeat (hold) begin
                @(negedge CLK);
                chk("oor_hold_busy", BUSY, 0);
                chk("oor_hold_err", ERR, exp_err);
            end
            START_FLAG = 1'b0;
            @(negedge CLK);
            chk("oor_idle_err", ERR, exp_err);
            chk("oor_idle_flag", RDY_FLAG, 0);
            chk("oor_idle_busy", BUSY, 0);
            chk("oor_idle_cnt", CYCLE_CNT, exp_cnt);
            return;
        end
        exp_sel = sel;
        ok      = !pre && d <= TO - 1;
        last    = ok ? d : TO - 1;
        chk("arm_start", DUT_START, 1);
        chk("arm_busy", BUSY, 1);
        chk("arm_err", ERR, 0);
        chk("arm_en", DUT_EN, oh(sel));
        rdy      = ND'($urandom);
        rdy[sel] = pre;
        for (int i = 0; i <= last; i++) begin
            @(negedge CLK);
            chk("run_start", DUT_START, 0);
            chk("run_busy", BUSY, 1);
            chk("run_en", DUT_EN, oh(sel));
            chk("run_head", HEAD_INFO, hexp(sel));
            SEL      = (alt >= 0) ? 2'(alt) : 2'($urandom);
            rdy      = ND'($urandom);
            rdy[sel] = pre || (i >= d);
        end
        @(negedge CLK);
        if (ok) begin
            exp_data = dval;
            exp_cnt  = CW'(d);
            exp_err  = 2'd0;
        end else begin
            exp_cnt  = CW'(TO - 1);
            exp_err  = 2'd1;
        end
        chk("end_flag", RDY_FLAG, ok);
        chk("end_err", ERR, exp_err);
        chk("end_data", DATA_OUT, exp_data);
        chk("end_cnt", CYCLE_CNT, exp_cnt);
        chk("end_busy", BUSY, 0);
        chk("end_start", DUT_START, 0);
        chk("end_en", DUT_EN, oh(sel));
        repeat (hold) begin
            SEL = 2'($urandom);
            @(negedge CLK);
            chk("hold_flag", RDY_FLAG, ok);
            chk("hold_busy", BUSY, 0);
            chk("hold_start", DUT_START, 0);
            chk("hold_cnt", CYCLE_CNT, exp_cnt);
        end
        START_FLAG = 1'b0;
        SEL        = 2'(sel);
        rdy        = '0;
        @(negedge CLK);
        chk("idle_flag", RDY_FLAG, 0);
        chk("idle_busy", BUSY, 0);
        chk("idle_err", ERR, exp_err);
        chk("idle_data", DATA_OUT, exp_data);
        chk("idle_cnt", CYCLE_CNT, exp_cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int k = 0; k < ND; k++) begin
            dout[k] = BW'($urandom);
            head[k] = HW'($urandom);
        end
        rdy        = '0;
        RST        = 1'b1;
        START_FLAG = 1'b0;
        SEL        = 2'd2;
        DATA_IN    = '0;
        exp_sel    = 0;
        exp_data   = '0;
        exp_cnt    = '0;
        exp_err    = 2'd0;
        repeat (3) @(negedge CLK);
        chk("rst_en", DUT_EN, 3'b001);
        chk("rst_start", DUT_START, 0);
        chk("rst_data", DATA_OUT, 0);
        chk("rst_cnt", CYCLE_CNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_flag", RDY_FLAG, 0);
        chk("rst_err", ERR, 0);
        chk("rst_head", HEAD_INFO, hexp(0));
        RST = 1'b0;
        SEL = 2'd0;
        @(negedge CLK);

        run_txn(0, 2, 1'b0, 0, 16'h1234, -1);
        run_txn(2, 99, 1'b1, 0, 16'hbeef, -1);
        run_txn(3, 0, 1'b0, 2, 16'h0000, -1);
        run_txn(1, 5, 1'b0, 0, 16'h5a5a, 0);

        // Reset in the middle of a run.
        SEL        = 2'd1;
        START_FLAG = 1'b1;
        rdy        = '0;
        @(negedge CLK);
        chk("rr_start", DUT_START, 1);
        repeat (6) @(negedge CLK);
        chk("rr_busy", BUSY, 1);
        RST        = 1'b1;
        START_FLAG = 1'b0;
        @(negedge CLK);
        chk("rr_en", DUT_EN, 3'b001);
        chk("rr_start", DUT_START, 0);
        chk("rr_data", DATA_OUT, 0);
        chk("rr_cnt", CYCLE_CNT, 0);
        chk("rr_busy", BUSY, 0);
        chk("rr_flag", RDY_FLAG, 0);
        chk("rr_err", ERR, 0);
        RST      = 1'b0;
        exp_sel  = 0;
        exp_data = '0;
        exp_cnt  = '0;
        exp_err  = 2'd0;
        run_txn(1, 4, 1'b0, 0, 16'h0f0f, -1);

        // Start held across DONE, then a second edge.
        run_txn(0, 3, 1'b0, 10, 16'hcafe, -1);
        run_txn(0, 7, 1'b0, 0, 16'hd00d, -1);

        // Completion on the last cycle before timeout, then first timeout.
        run_txn(2, TO - 1, 1'b0, 0, 16'h7777, -1);
        run_txn(1, TO, 1'b0, 0, 16'h8888, -1);

        for (int n = 0; n < 30; n++) begin
            int  s;
            bit  p;
            s = $urandom_range(0, 3);
            p = ($urandom_range(0, 3) == 0);
            run_txn(s, p ? 99 : $urandom_range(0, 20), p,
                    $urandom_range(0, 4), BW'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dut_test_sequencer.md
Name: dut_test_sequencer

Overview:
Parametrised successor of the DUT test-environment mux. It selects one of NUM_DUT device-under-test slots and runs a start/ready transaction against the selected slot. It measures the latency in clock cycles, guards the run with a timeout watchdog, and registers the result data, header and status for the host-side readout logic. It sits between the host command interface and the DUT slot instances.

Parameters:
BITWIDTH_DATA, 16, data width of DUT inputs and outputs
NUM_DUT, 3, number of DUT slots (1..63)
NUM_BITS_HEADER, 32, header width; the top 6 bits carry NUM_DUT
CNT_WIDTH, 24, width of the latency counter
TIMEOUT_CYCLES, 1000000, RUN cycles before abort; 0 disables the timeout. Must be < 2^CNT_WIDTH.

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST  in  1  synchronous, active-high reset
START_FLAG  in  1  level request from host; rising edge starts a run
SEL  in  SW=max(1,$clog2(NUM_DUT))  requested DUT slot
DATA_IN  in  BITWIDTH_DATA  passed through unregistered to DUT_DIN
DUT_EN  out  NUM_DUT  one-hot enable of the latched slot
DUT_START  out  1  one-cycle start pulse to the DUTs
DUT_DIN  out  BITWIDTH_DATA  = DATA_IN
DUT_DOUT  in  NUM_DUT*BITWIDTH_DATA  flattened DUT outputs; slot k at [k*BW +: BW]
DUT_HEAD  in  NUM_DUT*(NUM_BITS_HEADER-6)  flattened DUT headers
DUT_RDY  in  NUM_DUT  DUT ready/valid flags
DATA_OUT  out  BITWIDTH_DATA  registered result of the last completed run
HEAD_INFO  out  NUM_BITS_HEADER  {NUM_DUT[5:0], header of the latched slot}, combinational on sel_q
CYCLE_CNT  out  CNT_WIDTH  latency of the last run
BUSY  out  1  high in ARM and RUN
RDY_FLAG  out  1  high in DONE
ERR  out  2  0 = ok, 1 = timeout, 2 = SEL out of range

Behaviour:
- Reset values: state = IDLE; sel_q = 0; DUT_EN = one-hot(0); DUT_START, DATA_OUT, CYCLE_CNT, BUSY, RDY_FLAG, ERR all 0; start_q = 0; rdy_prev = 0.
- start_q is START_FLAG registered once. A start event is START_FLAG & ~start_q.
- IDLE:
  - sel_q <= SEL every cycle when SEL < NUM_DUT; otherwise sel_q holds.
  - Start event with SEL < NUM_DUT -> ARM: counter <= 0, ERR <= 0, DUT_START <= 1 for exactly one cycle.
  - Start event with SEL >= NUM_DUT -> ERRST with ERR <= 2; no DUT_START.
- ARM (1 cycle):
  - sel_q is frozen from here until the state returns to IDLE.
  - rdy_prev <= DUT_RDY[sel_q].
  - Next state is RUN.
- RUN:
  - Counter increments every cycle, saturating at all-ones.
  - rdy_prev tracks DUT_RDY[sel_q].
  - Completion is a rising edge of DUT_RDY[sel_q] (high now, rdy_prev low). A RDY already high at ARM does not complete the run.
  - On completion: DATA_OUT <= DUT_DOUT slice, CYCLE_CNT <= counter, go to DONE.
  - Latency definition: RDY first high on the cycle after ARM gives CYCLE_CNT = 0; k cycles later gives k.
  - Timeout: TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 with no completion in that cycle -> ERRST with ERR <= 1 and CYCLE_CNT <= counter. DATA_OUT keeps its previous value.
  - Completion and timeout in the same cycle: completion wins.
- DONE / ERRST:
  - RDY_FLAG = 1 in DONE only. ERR holds its value.
  - Exit to IDLE when START_FLAG == 0. The host must drop START to re-arm.
  - On exit to IDLE, RDY_FLAG -> 0. ERR, DATA_OUT and CYCLE_CNT persist until the next start event.
- START_FLAG edges outside IDLE are ignored. A START held high across DONE causes no restart.
- DUT_EN = one-hot(sel_q) in all states. Changing SEL during ARM or RUN has no effect on DUT_EN or HEAD_INFO.
- Reset asserted mid-run forces IDLE and all reset values on the next edge. Any DUT_START pulse in progress is dropped.
- NUM_DUT = 1: SW = 1; SEL = 1 is out of range.

Test Plan:
- Echo-style slot 0 raises RDY 3 cycles after DUT_START with DOUT = 0x1234, SEL = 0 -> DUT_EN = 001, single DUT_START pulse, DATA_OUT = 0x1234, CYCLE_CNT = 2, RDY_FLAG = 1, ERR = 0; START low -> IDLE, RDY_FLAG = 0.
- SEL = 2, slot 2 RDY held high before START and never toggles, TIMEOUT_CYCLES = 16 -> ERRST, ERR = 1, CYCLE_CNT = 15, DATA_OUT unchanged, RDY_FLAG = 0.
- SEL = 3 with NUM_DUT = 3 -> no DUT_START, ERR = 2, BUSY never high.
- SEL switched 1 -> 0 mid-RUN -> DUT_EN stays 010, HEAD_INFO = {6'd3, head1}, completion is taken from slot 1.
- RST asserted at RUN counter 5 -> next cycle IDLE, all outputs 0; a fresh START then runs normally.
- START held high through DONE for 10 cycles -> exactly one run; a second rising edge of START triggers a second run with its own CYCLE_CNT.
